dt_skeleton_scan: RTL and testbench

//  Downstream of the distance-transform stage: once DT has filled res memory (128x128, 8-bit distances),

---
 rtl/dt_pkg.sv | 27 ++
 rtl/skel_packer.sv | 47 ++++
 rtl/dt_skeleton_scan.sv | 207 ++++++++++++++++++++
 tb/tb_dt_skeleton_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared distance-transform definitions: image geometry, pixel/word address
// types and the skeleton scanner state encoding.
package dt_pkg;

    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int DW    = 8;

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    typedef logic [DW-1:0]        dist_t;
    typedef logic [YW+XW-1:0]     pix_addr_t;
    typedef logic [YW+XW-4-1:0]   skel_addr_t;

    // Each image column costs four cycles: three neighbour fetches plus a
    // shift/evaluate cycle.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_R_T   = 3'd1,
        S_R_M   = 3'd2,
        S_R_B   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } scan_state_e;

endpackage

// File: rtl/skel_packer.sv
// Collects skeleton bits MSB-first into a 16-bit word and presents the full
// word with a one-cycle write strobe once the sixteenth bit has arrived.
module skel_packer (
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic        i_clr,
    input  logic        i_shift,
    input  logic        i_bit,
    input  logic        i_last,
    output logic        o_wr,
    output logic [15:0] o_word
);

    logic [15:0] r_sr;
    logic [15:0] r_word;
    logic        r_wr;
    logic [15:0] w_sr_next;

    // New bit enters at the LSB so the first pixel of a word ends up at bit 15.
    assign w_sr_next[0] = i_bit;
    generate
        for (genvar gi = 1; gi < 16; gi++) begin : g_shift
            assign w_sr_next[gi] = r_sr[gi-1];
        end
    endgenerate

    // Shift register, completed-word latch and write strobe.
    always_ff @(posedge clk) begin
        if (!i_reset_n || i_clr) begin
            r_sr   <= '0;
            r_word <= '0;
            r_wr   <= 1'b0;
        end else begin
            r_wr <= i_shift && i_last;
            if (i_shift) begin
                r_sr <= w_sr_next;
                if (i_last) begin
                    r_word <= w_sr_next;
                end
            end
        end
    end

    assign o_wr   = r_wr;
    assign o_word = r_word;

endmodule

// File: rtl/dt_skeleton_scan.sv
// Raster scan of the distance map that marks 4-neighbour local maxima of
// nonzero distance as skeleton pixels, writes them as packed 16-bit words
// and tracks the largest distance seen.
module dt_skeleton_scan #(
    parameter int IMG_W = dt_pkg::IMG_W,
    parameter int IMG_H = dt_pkg::IMG_H,
    parameter int DW    = dt_pkg::DW
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    output logic                                      done,
    output logic                                      res_rd,
    output logic [$clog2(IMG_H)+$clog2(IMG_W)-1:0]    res_addr,
    input  logic [DW-1:0]                             res_di,
    output logic                                      skel_wr,
    output logic [$clog2(IMG_H)+$clog2(IMG_W)-4-1:0]  skel_addr,
    output logic [15:0]                               skel_do,
    output logic [DW-1:0]                             max_dist
);

    import dt_pkg::*;

    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H);
    localparam int KW  = XW + 1;
    localparam int AW  = XW + YW;
    localparam int SAW = AW - 4;

    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [KW-1:0] K_END  = KW'(IMG_W);

    // Control state and scan position; r_k runs one past the last column so
    // the final pixel of a row can be evaluated against a zero right-hand
    // neighbour.
    scan_state_e    r_state;
    scan_state_e    w_state_next;
    logic [KW-1:0]  r_k;
    logic [YW-1:0]  r_y;

    // A read issued in the previous cycle; data is forced to zero otherwise.
    logic           r_rd_q;

    // Sliding 3x3 window: N is the column being fetched, Q the column under
    // evaluation, P the middle value one column to the left.
    logic [DW-1:0]  r_n_t;
    logic [DW-1:0]  r_n_m;
    logic [DW-1:0]  r_q_t;
    logic [DW-1:0]  r_q_m;
    logic [DW-1:0]  r_q_b;
    logic [DW-1:0]  r_p;
    logic [DW-1:0]  r_max;
    logic [SAW-1:0] r_skel_addr;

    logic           w_row_first;
    logic           w_row_last;
    logic           w_col_end;
    logic [YW-1:0]  w_y_up;
    logic [YW-1:0]  w_y_dn;
    logic           w_rd;
    logic [AW-1:0]  w_addr;
    logic [DW-1:0]  w_col_data;
    logic           w_eval;
    logic           w_bit;
    logic [XW-1:0]  w_x;
    logic           w_last_in_word;
    logic           w_start_scan;
    logic           w_pk_wr;
    logic [15:0]    w_pk_word;

    assign w_row_first    = (r_y == '0);
    assign w_row_last     = (r_y == Y_LAST);
    assign w_col_end      = (r_k == K_END);
    assign w_y_up         = r_y - YW'(1);
    assign w_y_dn         = r_y + YW'(1);
    assign w_col_data     = r_rd_q ? res_di : '0;
    assign w_start_scan   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Pixel under evaluation is one column behind the fetch column; at
    // k == IMG_W the low bits wrap to the last pixel of the row.
    assign w_x            = r_k[XW-1:0] - XW'(1);
    assign w_eval         = (r_state == S_SHIFT) && (r_k != '0);
    assign w_last_in_word = (w_x[3:0] == 4'hF);

    // Ties with neighbours still count, so plateaus stay fully marked.
    assign w_bit = (r_q_m != '0) &&
                   (r_q_m >= r_q_t) && (r_q_m >= r_q_b) &&
                   (r_q_m >= r_p)   && (r_q_m >= r_n_m);

    // Read request for the neighbour row belonging to the current fetch
    // state; out-of-image rows and the padding column are never read.
    always_comb begin
        w_rd   = 1'b0;
        w_addr = '0;
        case (r_state)
            S_R_T: begin
                w_rd = !w_row_first && !w_col_end;
                if (w_rd) w_addr = {w_y_up, r_k[XW-1:0]};
            end
            S_R_M: begin
                w_rd = !w_col_end;
                if (w_rd) w_addr = {r_y, r_k[XW-1:0]};
            end
            S_R_B: begin
                w_rd = !w_row_last && !w_col_end;
                if (w_rd) w_addr = {w_y_dn, r_k[XW-1:0]};
            end
            default: begin
                w_rd   = 1'b0;
                w_addr = '0;
            end
        endcase
    end

    // Next-state sequencing of the four-cycle column fetch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_R_T;
            S_R_T:   w_state_next = S_R_M;
            S_R_M:   w_state_next = S_R_B;
            S_R_B:   w_state_next = S_SHIFT;
            S_SHIFT: w_state_next = (w_col_end && w_row_last) ? S_DONE : S_R_T;
            S_DONE:  if (start) w_state_next = S_R_T;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register, scan counters, window shift and running maximum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_y         <= '0;
            r_rd_q      <= 1'b0;
            r_n_t       <= '0;
            r_n_m       <= '0;
            r_q_t       <= '0;
            r_q_m       <= '0;
            r_q_b       <= '0;
            r_p         <= '0;
            r_max       <= '0;
            r_skel_addr <= '0;
        end else begin
            r_state <= w_state_next;
            r_rd_q  <= w_rd;
            case (r_state)
                S_R_M: r_n_t <= w_col_data;
                S_R_B: r_n_m <= w_col_data;
                S_SHIFT: begin
                    if (w_eval) begin
                        if (r_q_m > r_max) r_max <= r_q_m;
                        if (w_last_in_word) r_skel_addr <= {r_y, w_x[XW-1:4]};
                    end
                    if (w_col_end) begin
                        // Row finished: window restarts empty on the next row.
                        r_k   <= '0;
                        r_p   <= '0;
                        r_q_t <= '0;
                        r_q_m <= '0;
                        r_q_b <= '0;
                        if (!w_row_last) r_y <= r_y + YW'(1);
                    end else begin
                        r_k   <= r_k + KW'(1);
                        r_p   <= r_q_m;
                        r_q_t <= r_n_t;
                        r_q_m <= r_n_m;
                        r_q_b <= w_col_data;
                    end
                end
                default: begin
                end
            endcase
            if (w_start_scan) begin
                r_k   <= '0;
                r_y   <= '0;
                r_n_t <= '0;
                r_n_m <= '0;
                r_q_t <= '0;
                r_q_m <= '0;
                r_q_b <= '0;
                r_p   <= '0;
                r_max <= '0;
            end
        end
    end

    skel_packer u_packer (
        .clk       (clk),
        .i_reset_n (reset),
        .i_clr     (w_start_scan),
        .i_shift   (w_eval),
        .i_bit     (w_bit),
        .i_last    (w_last_in_word),
        .o_wr      (w_pk_wr),
        .o_word    (w_pk_word)
    );

    assign done      = (r_state == S_DONE);
    assign res_rd    = w_rd;
    assign res_addr  = w_addr;
    assign skel_wr   = w_pk_wr;
    assign skel_addr = r_skel_addr;
    assign skel_do   = w_pk_word;
    assign max_dist  = r_max;

endmodule

// File: tb/tb_dt_skeleton_scan.sv
// Directed bench for dt_skeleton_scan on a 32x16 image so that several full
// scans fit in a short run; expected skeleton words are written out by hand.
module tb_dt_skeleton_scan;

    localparam int W     = 32;
    localparam int H     = 16;
    localparam int DW    = 8;
    localparam int AW    = 9;
    localparam int SAW   = 5;
    localparam int NWORD = H * W / 16;
    // Four cycles per column, W+1 columns per row (one padding column).
    localparam int SCAN_CYC = H * (W + 1) * 4;
    // Per row: W middle reads, W top reads except row 0, W bottom reads
    // except the last row; the padding column is never read.
    localparam int NREAD = W * (3 * H - 2);

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           done;
    logic           res_rd;
    logic [AW-1:0]  res_addr;
    logic [DW-1:0]  res_di = '0;
    logic           skel_wr;
    logic [SAW-1:0] skel_addr;
    logic [15:0]    skel_do;
    logic [DW-1:0]  max_dist;

    logic [7:0]  mem      [0:W*H-1];
    logic [15:0] exp_skel [0:NWORD-1];
    logic [15:0] got_skel [0:NWORD-1];
    int wr_cnt, rd_cnt, rd_row0, rd_rowl;
    int n_vec = 0;
    int n_err = 0;

    dt_skeleton_scan #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .res_rd    (res_rd),
        .res_addr  (res_addr),
        .res_di    (res_di),
        .skel_wr   (skel_wr),
        .skel_addr (skel_addr),
        .skel_do   (skel_do),
        .max_dist  (max_dist)
    );

    always #5 clk = ~clk;

    // Distance memory: one-cycle registered read.
    always @(posedge clk) begin
        if (res_rd) res_di <= mem[res_addr];
    end

    // Scoreboard capture of writes and read counts, away from the edge.
    always @(negedge clk) begin
        if (skel_wr) begin
            got_skel[skel_addr] = skel_do;
            wr_cnt = wr_cnt + 1;
        end
        if (res_rd) begin
            rd_cnt = rd_cnt + 1;
            if (res_addr[AW-1:5] == 4'd0)  rd_row0 = rd_row0 + 1;
            if (res_addr[AW-1:5] == 4'd15) rd_rowl = rd_rowl + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < W * H; i++) mem[i] = 8'd0;
        for (int i = 0; i < NWORD; i++) exp_skel[i] = 16'h0000;
    endtask

    task automatic set_px(input int y, input int x, input int v);
        mem[y * W + x] = 8'(v);
    endtask

    task automatic clear_score();
        wr_cnt = 0; rd_cnt = 0; rd_row0 = 0; rd_rowl = 0;
        for (int i = 0; i < NWORD; i++) got_skel[i] = 16'hDEAD;
    endtask

    // One complete scan from IDLE/DONE; poke_at > 0 pulses start mid-scan.
    task automatic run_scan(input string name, input int exp_max, input int poke_at);
        int cyc;
        clear_score();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({name, "_done_clr"}, done, 0);
        chk({name, "_max_clr"}, max_dist, 0);
        cyc = 0;
        while (cyc < SCAN_CYC + 200) begin
            @(posedge clk);
            cyc++;
            #1;
            start = (cyc == poke_at);
            if (done) break;
        end
        start = 1'b0;
        chk({name, "_done_cycle"}, cyc, SCAN_CYC);
        @(negedge clk);
        #1;
        chk({name, "_writes"}, wr_cnt, NWORD);
        chk({name, "_reads"}, rd_cnt, NREAD);
        chk({name, "_reads_row0"}, rd_row0, 2 * W);
        chk({name, "_reads_rowlast"}, rd_rowl, 2 * W);
        chk({name, "_max"}, max_dist, exp_max);
        for (int i = 0; i < NWORD; i++)
            chk($sformatf("%s_word%0d", name, i), got_skel[i], exp_skel[i]);
        $display("scan %s: %0d cycles, %0d writes, %0d reads, max %0d",
                 name, cyc, wr_cnt, rd_cnt, max_dist);
    endtask

    task automatic load_ramp();
        clear_img();
        for (int y = 1; y < H - 1; y++) begin
            for (int x = 0; x < W - 1; x++) set_px(y, x, x);
            exp_skel[y * 2 + 1] = 16'h0002;
        end
    endtask

    initial begin
        clear_img();
        clear_score();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_res_rd", res_rd, 0);
        chk("rst_skel_wr", skel_wr, 0);
        chk("rst_res_addr", res_addr, 0);
        chk("rst_skel_addr", skel_addr, 0);
        chk("rst_skel_do", skel_do, 0);
        chk("rst_max", max_dist, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // All-zero distances: every word zero.
        run_scan("zero", 0, 0);

        // Isolated pixel (5,20)=3: word {5,1}, bit for x[3:0]=4 is bit 11.
        clear_img();
        set_px(5, 20, 3);
        exp_skel[5 * 2 + 1] = 16'h0800;
        run_scan("single", 3, 0);

        // Plateau of 2 on row 10 cols 16..31 surrounded by 1s: ties keep
        // the whole word; a stray start mid-scan must not disturb anything.
        clear_img();
        for (int x = 16; x < 32; x++) begin
            set_px(10, x, 2);
            set_px(9, x, 1);
            set_px(11, x, 1);
        end
        set_px(10, 15, 1);
        exp_skel[10 * 2 + 1] = 16'hFFFF;
        run_scan("plateau", 2, 700);

        // Ramp value = x on rows 1..14, cols 0..30: only col 30 survives
        // (bit 1 of word {y,1}).
        load_ramp();
        run_scan("ramp", 30, 0);

        // Reset in the middle of a scan, then a clean rescan.
        load_ramp();
        clear_score();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (1000) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_done", done, 0);
        chk("abort_res_rd", res_rd, 0);
        chk("abort_skel_wr", skel_wr, 0);
        chk("abort_res_addr", res_addr, 0);
        chk("abort_skel_addr", skel_addr, 0);
        chk("abort_skel_do", skel_do, 0);
        chk("abort_max", max_dist, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        wr_cnt = 0;
        rd_cnt = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_quiet_wr", wr_cnt, 0);
        chk("abort_quiet_rd", rd_cnt, 0);
        chk("abort_quiet_done", done, 0);
        $display("abort: reset applied mid-scan, idle for 20 cycles");
        run_scan("rescan", 30, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
